ex_muldiv_unit: RTL
===================

# ex_muldiv_unit

Sequential multiply/divide unit for the EX stage, operating on the same forwarded rs/rt operands the ALU receives and owning the architectural HI/LO registers. It performs MULT, MULTU, DIV, DIVU, MTHI and MTLO. Its datapath width is parametrised, and the multiplier can be built iterative or single-cycle. It drives a stall request to the hazard logic while busy, so that a dependent MFHI/MFLO or a second mult/div waits for the result.

## Interface
- BUS_SIZE, 32: operand, HI and LO width; must be ≥ 4.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request: execute i_op this cycle.
- i_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; codes 6–7 are no-ops.
- i_data_a  in  BUS_SIZE  rs value, after forwarding: multiplicand, dividend, or MTHI/MTLO source.
- i_data_b  in  BUS_SIZE  rt value, after forwarding: multiplier or divisor.
- i_hilo_read  in  1  EX holds MFHI/MFLO this cycle.
- i_flush  in  1  abort any in-flight operation.
- o_busy  out  1  state ≠ IDLE; combinational from state.
- o_stall  out  1  o_busy & (i_start | i_hilo_read); combinational.
- o_done  out  1  registered one-cycle pulse; HI/LO are updated in the same cycle.
- o_div_by_zero  out  1  registered pulse coincident with o_done for DIV/DIVU with i_data_b = 0.
- o_hi  out  BUS_SIZE  HI register.
- o_lo  out  BUS_SIZE  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, i_start, op 0–3:
  - Latch operands into working registers.
  - For signed ops, latch magnitudes plus the result signs: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the iteration counter; go to CALC.
- IDLE, i_start, op 4/5:
  - Write HI (op 4) or LO (op 5) with i_data_a at that edge; stay in IDLE.
  - o_done does not pulse.
- CALC:
  - Multiply: one radix-2 shift-add step per cycle.
  - Divide: one restoring step per cycle.
  - Exactly BUS_SIZE cycles, then go to FIX.
- FIX, multiply:
  - Apply two's-complement negation to the 2·BUS_SIZE-bit product when needed.
  - HI = upper half, LO = lower half.
- FIX, divide:
  - LO = quotient, HI = remainder, each with its sign applied.
- FIX exit: write HI/LO, set o_done (and o_div_by_zero if applicable), return to IDLE.
- Divide by zero: HI = dividend (original, signed form), LO = all ones; o_div_by_zero = 1.
- Signed overflow (MIN / −1): LO = MIN, HI = 0. The magnitude path produces this naturally; no special case is needed.
- i_start while busy: ignored. o_stall = 1 tells the pipeline to hold the instruction.
- i_hilo_read while busy: o_stall = 1. o_hi/o_lo hold their old values until o_done.
- i_flush in CALC or FIX:
  - Next state is IDLE; HI/LO unchanged; no o_done.
  - i_flush in IDLE has no effect.
- i_flush together with i_start: the flush wins and nothing is accepted, including MTHI/MTLO.
- i_reset: has priority over everything. State = IDLE; HI, LO, working registers and counter = 0; o_done = o_div_by_zero = 0. This holds mid-operation too.

## Timing
- Cycle numbering: the edge sampling i_start ends cycle 0.
- Iterative mult/div:
  - CALC occupies cycles 1..BUS_SIZE; FIX is cycle BUS_SIZE+1.
  - o_done and the new HI/LO appear in cycle BUS_SIZE+2 (cycle 34 for BUS_SIZE = 32).
  - o_busy is high in cycles 1..BUS_SIZE+1.
- MTHI/MTLO: the new value is visible in cycle 1.
- Back-to-back: a new i_start is accepted in the o_done cycle, because the state is IDLE then.
- Reset values: o_busy = o_stall = o_done = o_div_by_zero = 0; o_hi = o_lo = 0.

## Configuration
- EX_MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU skip CALC; IDLE goes straight to FIX.
  - FIX computes the product with a single combinational multiply.
  - o_done appears in cycle 2; o_busy is high only in cycle 1.
  - Divides are unchanged.
- Undefined: all four ops take the iterative path with BUS_SIZE+2 latency.

## Structure
- Shared header ex_muldiv.vh, containing:
  - op codes (`EX_MULDIV_OP_*`);
  - state encodings;
  - `DEFAULT_EX_MULDIV_BUS_SIZE` = 32.
- Sub-module muldiv_step: combinational single-iteration datapath, parametrised by BUS_SIZE.
  - Inputs: mode (mul/div), partial accumulator, operand.
  - Outputs: next accumulator and next shifted operand.
  - The top level holds the FSM, counter, sign handling, HI/LO and handshake.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; o_done in cycle 34 (or cycle 2 with the macro defined).
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Division results:
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 7/0 → HI=7, LO=0xFFFFFFFF, o_div_by_zero=1.
- During CALC, drive i_hilo_read=1 and i_start=1 with MTLO → o_stall=1, LO unchanged, final result correct.
- MTHI 0x12345678 then immediately MFHI → o_hi=0x12345678 in cycle 1; no o_done pulse.
- i_flush in cycle 10 of a DIVU → o_busy=0 in cycle 11, HI/LO keep prior values, no o_done. Repeat the same test with i_reset in place of i_flush → all outputs are 0 in the next cycle.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared op codes, FSM state encoding and default width
// for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;
    localparam int DEFAULT_EX_MULDIV_BUS_SIZE = 32;
    localparam logic [2:0] EX_MULDIV_OP_MULT  = 3'd0;
    localparam logic [2:0] EX_MULDIV_OP_MULTU = 3'd1;
    localparam logic [2:0] EX_MULDIV_OP_DIV   = 3'd2;
    localparam logic [2:0] EX_MULDIV_OP_DIVU  = 3'd3;
    localparam logic [2:0] EX_MULDIV_OP_MTHI  = 3'd4;
    localparam logic [2:0] EX_MULDIV_OP_MTLO  = 3'd5;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;
endpackage

// File: rtl/ex_muldiv_unit_step.sv
// muldiv_step: one combinational radix-2 shift-add (mode=1) or restoring
// divide (mode=0) iteration over the {acc, opnd} working pair.
module muldiv_step #(
    parameter int BUS_SIZE = 32
) (
    input  logic                mode,
    input  logic [BUS_SIZE-1:0] acc,
    input  logic [BUS_SIZE-1:0] opnd,
    input  logic [BUS_SIZE-1:0] addend,
    output logic [BUS_SIZE-1:0] acc_next,
    output logic [BUS_SIZE-1:0] opnd_next
);
    logic [BUS_SIZE:0] sum, rem_sh, diff;
    logic              ge;
    assign sum    = {1'b0, acc} + (opnd[0] ? {1'b0, addend} : '0);
    assign rem_sh = {acc, opnd[BUS_SIZE-1]};
    assign diff   = rem_sh - {1'b0, addend};
    // remainder stays below the divisor, so bit BUS_SIZE of diff is the borrow
    assign ge     = !diff[BUS_SIZE];
    assign acc_next  = mode ? sum[BUS_SIZE:1] : (ge ? diff[BUS_SIZE-1:0] : rem_sh[BUS_SIZE-1:0]);
    assign opnd_next = mode ? {sum[0], opnd[BUS_SIZE-1:1]} : {opnd[BUS_SIZE-2:0], ge};
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: sequential MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Define EX_MULDIV_FAST_MUL_EN for a single-cycle multiplier (divides stay iterative).
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int BUS_SIZE = DEFAULT_EX_MULDIV_BUS_SIZE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [2:0]          i_op,
    input  logic [BUS_SIZE-1:0] i_data_a,
    input  logic [BUS_SIZE-1:0] i_data_b,
    input  logic                i_hilo_read,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_stall,
    output logic                o_done,
    output logic                o_div_by_zero,
    output logic [BUS_SIZE-1:0] o_hi,
    output logic [BUS_SIZE-1:0] o_lo
);
    localparam int CW = $clog2(BUS_SIZE);
    localparam logic [CW-1:0] LAST = CW'(BUS_SIZE - 1);
    state_e                state;
    logic [CW-1:0]         cnt;
    logic [BUS_SIZE-1:0]   acc, opnd, addend, acc_n, opnd_n, mag_a, mag_b, quot, rem;
    logic [2*BUS_SIZE-1:0] prod_raw, prod;
    logic                  is_mul, neg_q, neg_r, dz, signed_op, sa, sb;
    assign signed_op = !i_op[0];
    assign sa = signed_op & i_data_a[BUS_SIZE-1];
    assign sb = signed_op & i_data_b[BUS_SIZE-1];
    assign mag_a = sa ? -i_data_a : i_data_a;
    assign mag_b = sb ? -i_data_b : i_data_b;
    assign o_busy  = state != IDLE;
    assign o_stall = o_busy & (i_start | i_hilo_read);
    muldiv_step #(.BUS_SIZE(BUS_SIZE)) u_step (
        .mode(is_mul), .acc(acc), .opnd(opnd), .addend(addend),
        .acc_next(acc_n), .opnd_next(opnd_n)
    );
`ifdef EX_MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    assign prod_raw = {{BUS_SIZE{1'b0}}, opnd} * {{BUS_SIZE{1'b0}}, addend};
`else
    localparam bit FAST_MUL = 1'b0;
    assign prod_raw = {acc, opnd};
`endif
    assign prod = neg_q ? -prod_raw : prod_raw;
    // divide by zero leaves the dividend in acc; LO is forced to all ones
    assign quot = dz ? '1 : (neg_q ? -opnd : opnd);
    assign rem  = neg_r ? -acc : acc;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            opnd <= '0;
            addend <= '0;
            is_mul <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            o_hi <= '0;
            o_lo <= '0;
            o_done <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_div_by_zero <= 1'b0;
            case (state)
                IDLE: if (i_start && !i_flush) begin
                    if (!i_op[2]) begin
                        acc <= '0;
                        opnd <= i_op[1] ? mag_a : mag_b;
                        addend <= i_op[1] ? mag_b : mag_a;
                        is_mul <= !i_op[1];
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        dz <= i_op[1] && i_data_b == '0;
                        cnt <= '0;
                        state <= (FAST_MUL && !i_op[1]) ? FIX : CALC;
                    end else if (i_op == EX_MULDIV_OP_MTHI) begin
                        o_hi <= i_data_a;
                    end else if (i_op == EX_MULDIV_OP_MTLO) begin
                        o_lo <= i_data_a;
                    end
                end
                CALC: if (i_flush) begin
                    state <= IDLE;
                end else begin
                    acc <= acc_n;
                    opnd <= opnd_n;
                    cnt <= cnt + 1'b1;
                    state <= (cnt == LAST) ? FIX : CALC;
                end
                FIX: begin
                    state <= IDLE;
                    if (!i_flush) begin
                        o_hi <= is_mul ? prod[2*BUS_SIZE-1:BUS_SIZE] : rem;
                        o_lo <= is_mul ? prod[BUS_SIZE-1:0] : quot;
                        o_done <= 1'b1;
                        o_div_by_zero <= dz;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
